cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Execution controller for the single-cycle RISC-V CPU on the Nexys A7 board. Turns a raw step push-button and a run switch into a clock-enable for the CPU, with free-run, single-step, hardware-breakpoint and ebreak/ecall halting. Counts executed cycles. Sits between board I/O and the CPU's `cpu_en` input.

## Interface
- `DEB_CYCLES`, default 1000000: consecutive stable cycles a synchronized input must hold before its debounced level changes (≥1).
- `PC_W`, default 32: PC / breakpoint width.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `btn_step`  in  1  raw step push-button, asynchronous
- `sw_run`  in  1  raw run switch, asynchronous
- `bp_en`  in  1  breakpoint enable, quasi-static
- `bp_addr`  in  PC_W  breakpoint address
- `pc`  in  PC_W  CPU's current PC
- `halt_req`  in  1  CPU decodes ebreak/ecall at `pc`
- `cpu_en`  out  1  CPU advances one instruction on each clk edge where this is 1
- `state`  out  2  FSM state, for LED display
- `cycle_cnt`  out  32  count of cycles with `cpu_en`=1
- `step_done`  out  1  one-cycle pulse, cycle after a STEP

## Operation
- Inputs: 2-FF synchronizer each, then debouncer. Debounced level flips on the edge where synced value has differed from it for DEB_CYCLES consecutive cycles; any agreement resets the counter.
- `step_req`: registered rising edge of debounced step (1-cycle pulse).
- States (2-bit): HALT=0, RUN=1, STEP=2, BREAK=3.
- `bp_hit` = `bp_en` && `pc`==`bp_addr` && !`resume`; `resume` is 1 only in the first cycle of RUN after HALT→RUN.
- `cpu_en` = (RUN && !`bp_hit` && !`halt_req`) || STEP; decoded from state register, no other logic path.
- HALT: `run_db` → RUN; else `step_req` → STEP. Both same cycle → RUN, step dropped.
- STEP: exactly one cycle; always → HALT. Ignores breakpoint and `halt_req` (executes the instruction).
- RUN: `run_db`=0 → HALT (highest priority); else `halt_req` or `bp_hit` → BREAK. Instruction at breakpoint/ebreak is not executed.
- BREAK: `cpu_en`=0; `run_db`=0 → HALT. `step_req` ignored.
- `step_done` registered: 1 in the cycle after STEP.
- `cycle_cnt` increments on each edge with `cpu_en`=1; wraps 2^32−1 → 0.
- Reset (async, mid-operation included): state HALT, `cpu_en` 0 immediately, `cycle_cnt` 0, `step_done` 0, sync FFs, debounced levels, debounce counters, edge register, `resume` all 0.

## Timing
- Raw input change → debounced change: 2 + DEB_CYCLES cycles when stable.
- Debounced step rise → `step_req`: 1 cycle; `step_req` → STEP (`cpu_en`=1): next edge. Total raw press → `cpu_en`: DEB_CYCLES+4 cycles.
- Debounced run rise in HALT → RUN next edge; `cpu_en`=1 that cycle.
- `bp_hit`/`halt_req` drop `cpu_en` in the same cycle (combinational); BREAK entered next edge.
- Exactly one `cpu_en` cycle per step press regardless of hold length.

## Structure
- Package `cpu_ctrl_pkg`: 2-bit state encoding constants (HALT/RUN/STEP/BREAK), `cycle_cnt` width.
- Sub-module `btn_debounce` (sync + counter + level register, parameter DEB_CYCLES), instantiated twice.
- FSM, breakpoint compare, counter in `cpu_run_ctrl`.

## Test plan (DEB_CYCLES=4)
- Reset with `sw_run`=1 held: `state`=0, `cpu_en`=0, `cycle_cnt`=0; after release, RUN reached 7 cycles later, `cycle_cnt` increments by 1 per cycle.
- Step press held 50 cycles, `sw_run`=0: `cpu_en` high exactly 1 cycle, 8 cycles after press; `step_done` next cycle; `cycle_cnt`=1.
- Button bounce 1-0-1-0 at 2-cycle spacing then stable 1: single STEP only.
- RUN, `bp_en`=1, `bp_addr`=0x10, `pc` reaches 0x10: `cpu_en`=0 that cycle, `state`=3 next; drop run → HALT; step → executes 0x10; re-run with `pc`=0x10 → no re-break in first cycle.
- RUN, `halt_req`=1 at cycle N: `cpu_en`=0 at N, BREAK at N+1, `cycle_cnt` frozen; concurrent run-fall and `halt_req` → HALT.
- Assert `rst`=0 mid-RUN: `cpu_en`, `state`, `cycle_cnt` 0 without a clock edge; force `cycle_cnt`=0xFFFFFFFF then one enabled cycle → 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU execution controller.
//   state_e      : 2-bit FSM encoding, also shown on the board LEDs
//   CYCLE_CNT_W  : width of the executed-cycle counter
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2,
    StBreak = 2'd3
  } state_e;

  localparam int unsigned CYCLE_CNT_W = 32;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a raw asynchronous board input through two flops, then debounces it.
// The level output changes only after the synchronized value has disagreed with it
// for DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   din   : raw asynchronous input
//   level : debounced level
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        // DEB_CYCLES-th consecutive disagreeing cycle: accept the new level
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the single-cycle CPU: turns the step button and run switch
// into the CPU clock-enable, with free-run, single-step, breakpoint and ebreak/ecall halt.
//   clk, rst          : system clock, asynchronous active-low reset
//   btn_step, sw_run  : raw board inputs (asynchronous)
//   bp_en, bp_addr    : hardware breakpoint enable and address
//   pc, halt_req      : CPU's current PC and ebreak/ecall decode at that PC
//   cpu_en            : CPU executes one instruction on each edge where this is 1
//   state             : FSM state for the LEDs
//   cycle_cnt         : number of edges with cpu_en=1 (wraps)
//   step_done         : one-cycle pulse in the cycle after a STEP
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned PC_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_step,
  input  logic                   sw_run,
  input  logic                   bp_en,
  input  logic [PC_W-1:0]        bp_addr,
  input  logic [PC_W-1:0]        pc,
  input  logic                   halt_req,
  output logic                   cpu_en,
  output logic [1:0]             state,
  output logic [CYCLE_CNT_W-1:0] cycle_cnt,
  output logic                   step_done
);

  logic                   run_db;
  logic                   step_db;
  logic                   step_db_q;
  logic                   step_req_q;
  logic                   resume_q;
  logic                   step_done_q;
  logic                   bp_hit;
  state_e                 state_q;
  logic [CYCLE_CNT_W-1:0] cnt_q;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_run_db (
    .clk  (clk),
    .rst  (rst),
    .din  (sw_run),
    .level(run_db)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_db (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_step),
    .level(step_db)
  );

  // resume masks the breakpoint for the first RUN cycle so we can leave a breakpoint PC
  assign bp_hit = bp_en && (pc == bp_addr) && !resume_q;

  // STEP always executes, even on a breakpoint or ebreak/ecall
  assign cpu_en = ((state_q == StRun) && !bp_hit && !halt_req) || (state_q == StStep);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StHalt;
      step_db_q   <= 1'b0;
      step_req_q  <= 1'b0;
      resume_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      step_db_q   <= step_db;
      step_req_q  <= step_db && !step_db_q;
      resume_q    <= (state_q == StHalt) && run_db;
      step_done_q <= (state_q == StStep);
      unique case (state_q)
        StHalt: begin
          // run wins over a simultaneous step request; the step is dropped
          if (run_db) begin
            state_q <= StRun;
          end else if (step_req_q) begin
            state_q <= StStep;
          end
        end
        StStep: state_q <= StHalt;
        StRun: begin
          if (!run_db) begin
            state_q <= StHalt;
          end else if (halt_req || bp_hit) begin
            state_q <= StBreak;
          end
        end
        StBreak: begin
          if (!run_db) begin
            state_q <= StHalt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CYCLE_CNT_W'(cpu_en);
    end
  end

  assign state     = state_q;
  assign cycle_cnt = cnt_q;
  assign step_done = step_done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_step;
  logic        sw_run;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic        step_done;

  int errors = 0;
  int checks = 0;

  cpu_run_ctrl #(
    .DEB_CYCLES(4),
    .PC_W      (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_step (btn_step),
    .sw_run   (sw_run),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .halt_req (halt_req),
    .cpu_en   (cpu_en),
    .state    (state),
    .cycle_cnt(cycle_cnt),
    .step_done(step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample point: just after the falling edge, well away from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic run);
    rst      = 1'b0;
    btn_step = 1'b0;
    sw_run   = run;
    bp_en    = 1'b0;
    bp_addr  = 32'h0;
    pc       = 32'h0;
    halt_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string tag);
    int n = 0;
    while (state !== s && n < max) begin
      tick();
      n++;
    end
    chk(tag, {30'd0, state}, {30'd0, s});
  endtask

  initial begin
    int n;
    int en_cnt, done_cnt, first_en, first_done;
    logic exp_en, first, broke;
    logic [31:0] exp_cnt;

    // ---- Reset with run held: outputs idle, RUN 7 cycles after release
    rst = 1'b0; btn_step = 1'b0; sw_run = 1'b1; bp_en = 1'b0;
    bp_addr = 32'h0; pc = 32'h0; halt_req = 1'b0;
    #1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_step_done", {31'd0, step_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (state !== 2'd1 && n < 20);
    chk("run_latency", n, 32'd7);
    for (int k = 0; k < 4; k++) begin
      chk("run_count", cycle_cnt, k);
      tick();
    end

    // ---- Step press held 50 cycles
    do_reset(1'b0);
    btn_step = 1'b1;
    en_cnt = 0; done_cnt = 0; first_en = 0; first_done = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (cpu_en === 1'b1) begin
        en_cnt++;
        if (first_en == 0) first_en = i;
      end
      if (step_done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
      end
      if (i == 50) btn_step = 1'b0;
    end
    chk("step_en_cycles", en_cnt, 32'd1);
    chk("step_latency", first_en, 32'd8);
    chk("step_done_cycles", done_cnt, 32'd1);
    chk("step_done_latency", first_done, 32'd9);
    chk("step_count", cycle_cnt, 32'd1);
    chk("step_back_halt", {30'd0, state}, 32'd0);

    // ---- Bounce 1-0-1-0 at 2-cycle spacing then stable 1
    do_reset(1'b0);
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      btn_step = (i < 8) ? (((i / 2) % 2) == 0) : (i < 38);
      tick();
      if (cpu_en === 1'b1) en_cnt++;
      if (step_done === 1'b1) done_cnt++;
    end
    chk("bounce_en_cycles", en_cnt, 32'd1);
    chk("bounce_done_cycles", done_cnt, 32'd1);
    chk("bounce_count", cycle_cnt, 32'd1);

    // ---- Breakpoint at 0x10, step over it, resume without re-break
    do_reset(1'b0);
    bp_en = 1'b1; bp_addr = 32'h10; sw_run = 1'b1;
    wait_state(2'd1, 20, "bp_enter_run");
    for (int p = 4; p < 16; p += 4) begin
      pc = p;
      #1;
      chk("bp_run_en", {31'd0, cpu_en}, 32'd1);
      tick();
    end
    pc = 32'h10;
    #1;
    chk("bp_hit_en", {31'd0, cpu_en}, 32'd0);
    tick();
    chk("bp_break_state", {30'd0, state}, 32'd3);
    chk("bp_break_en", {31'd0, cpu_en}, 32'd0);
    sw_run = 1'b0;
    wait_state(2'd0, 20, "bp_to_halt");
    btn_step = 1'b1;
    n = 0;
    while (cpu_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("bp_step_en", {31'd0, cpu_en}, 32'd1);
    chk("bp_step_state", {30'd0, state}, 32'd2);
    btn_step = 1'b0;
    tick();
    chk("bp_step_halt", {30'd0, state}, 32'd0);
    repeat (12) tick();
    sw_run = 1'b1;
    wait_state(2'd1, 20, "bp_rerun");
    chk("bp_resume_en", {31'd0, cpu_en}, 32'd1);
    tick();
    chk("bp_rebreak_en", {31'd0, cpu_en}, 32'd0);
    tick();
    chk("bp_rebreak_state", {30'd0, state}, 32'd3);

    // ---- halt_req during RUN freezes the counter
    do_reset(1'b1);
    pc = 32'h100;
    wait_state(2'd1, 20, "halt_enter_run");
    repeat (3) tick();
    halt_req = 1'b1;
    #1;
    chk("halt_en", {31'd0, cpu_en}, 32'd0);
    chk("halt_count", cycle_cnt, 32'd3);
    tick();
    chk("halt_break_state", {30'd0, state}, 32'd3);
    halt_req = 1'b0;
    tick();
    tick();
    chk("halt_frozen", cycle_cnt, 32'd3);
    chk("halt_stays_break", {30'd0, state}, 32'd3);

    // ---- run falling in the same cycle as halt_req goes to HALT
    do_reset(1'b1);
    pc = 32'h200;
    wait_state(2'd1, 20, "conc_enter_run");
    sw_run = 1'b0;
    repeat (6) tick();
    chk("conc_still_run", {30'd0, state}, 32'd1);
    halt_req = 1'b1;
    #1;
    chk("conc_en", {31'd0, cpu_en}, 32'd0);
    tick();
    chk("conc_to_halt", {30'd0, state}, 32'd0);
    halt_req = 1'b0;

    // ---- Asynchronous reset mid-RUN, then counter wrap
    do_reset(1'b1);
    wait_state(2'd1, 20, "arst_enter_run");
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_en", {31'd0, cpu_en}, 32'd0);
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_count", cycle_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_state(2'd1, 20, "wrap_enter_run");
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_preload", cycle_cnt, 32'hFFFF_FFFF);
    tick();
    chk("wrap_zero", cycle_cnt, 32'd0);

    // ---- Randomized RUN sessions against a behavioural model
    do_reset(1'b0);
    exp_cnt = 32'd0;
    bp_addr = 32'h40;
    for (int r = 0; r < 8; r++) begin
      sw_run = 1'b1;
      wait_state(2'd1, 20, "rnd_enter_run");
      first = 1'b1;
      broke = 1'b0;
      for (int c = 0; c < 30 && !broke; c++) begin
        bp_en    = 1'($urandom_range(0, 1));
        pc       = ($urandom_range(0, 3) == 0) ? 32'h40 : ($urandom & 32'hFC);
        halt_req = ($urandom_range(0, 9) == 0);
        if (c == 29) halt_req = 1'b1;
        #1;
        // first cycle after entering RUN never breaks on the breakpoint
        exp_en = !halt_req && !(bp_en && (pc == bp_addr) && !first);
        chk("rnd_en", {31'd0, cpu_en}, {31'd0, exp_en});
        chk("rnd_count", cycle_cnt, exp_cnt);
        if (exp_en) exp_cnt++;
        else broke = 1'b1;
        first = 1'b0;
        tick();
      end
      chk("rnd_break_state", {30'd0, state}, 32'd3);
      halt_req = 1'b0;
      bp_en    = 1'b0;
      sw_run   = 1'b0;
      wait_state(2'd0, 20, "rnd_to_halt");
      chk("rnd_final_count", cycle_cnt, exp_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
